// File: rtl/ysyx_24100005_mem_responder.sv
// Memory-side responder for the core load/store port: one outstanding read or
// byte-masked write, fixed access latency, word array mapped at ADDR_BASE.
module ysyx_24100005_mem_responder #(
   parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
   parameter int          DEPTH_LOG2 = 10,
   parameter int          LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            lat_wen;
   logic [31:0]     lat_addr;
   logic [31:0]     lat_wdata;
   logic [3:0]      lat_wmask;
   logic            rd_sel;
   logic            err;

   logic            acc_wen;
   logic [31:0]     acc_addr;
   logic [31:0]     acc_wdata;
   logic [3:0]      acc_wmask;
   logic [31:0]     off;
   logic            in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic            do_access;
   logic [31:0]     rd_word;

   // In IDLE the access (LATENCY==1 only) works on the live request; otherwise on the latched one.
   always_comb begin
      acc_wen   = lat_wen;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wmask = lat_wmask;
      if (state == IDLE) begin
         acc_wen   = req_wen;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_wmask = req_wmask;
      end
      off       = acc_addr - ADDR_BASE;
      in_range  = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
      idx       = off[DEPTH_LOG2+1:2];
      do_access = rst && (((state == IDLE) && req_valid && (LATENCY == 1)) ||
                          ((state == WAIT) && (cnt == '0)));
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_b [DEPTH];
         logic [7:0] rd_q;
         always_ff @(posedge clk) begin
            if (do_access && in_range) begin
               if (acc_wen) begin
                  if (acc_wmask[gi]) mem_b[idx] <= acc_wdata[8*gi +: 8];
               end else begin
                  rd_q <= mem_b[idx];
               end
            end
         end
         assign rd_word[8*gi +: 8] = rd_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_wen   <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wmask <= '0;
         rd_sel    <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_wen   <= req_wen;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_wmask <= req_wmask;
                  if (LATENCY == 1) begin
                     state  <= RESP;
                     rd_sel <= !req_wen && in_range;
                     err    <= !in_range;
                  end else begin
                     state  <= WAIT;
                     cnt    <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state  <= RESP;
                  rd_sel <= !lat_wen && in_range;
                  err    <= !in_range;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state  <= IDLE;
                  rd_sel <= 1'b0;
                  err    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // rd_word only changes on a read access, so the response stays stable in RESP.
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rd_sel ? rd_word : 32'd0;
   assign rsp_err   = err;

endmodule

// File: tb/tb_ysyx_24100005_mem_responder.sv
// Table-driven bench for the memory responder with a response scoreboard and
// hand-written sequences for backpressure and reset-abort cases.
module tb_ysyx_24100005_mem_responder;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wmask = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   ysyx_24100005_mem_responder #(
      .ADDR_BASE(32'h8000_0000), .DEPTH_LOG2(10), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      string       name;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one request, wait for its response, compare against the scoreboard, handshake.
   task automatic do_txn(input string name, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask,
                         input logic [31:0] exp_rdata, input logic exp_err);
      exp_t e;
      int   k;
      @(negedge clk);
      check({name, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
      e.rdata = exp_rdata; e.err = exp_err;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      k = 1;
      while (!rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({name, " latency"}, 32'(k), 32'(LAT));
      if (!rsp_valid) begin
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      check({name, " rdata"}, rsp_rdata, e.rdata);
      check({name, " err"}, 32'(rsp_err), 32'(e.err));
      $display("txn %s wen=%0b addr=%h rdata=%h err=%0b lat=%0d", name, wen, addr, rsp_rdata, rsp_err, k);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({name, " rsp_valid after hs"}, 32'(rsp_valid), 32'd0);
      check({name, " req_ready after hs"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      exp_t e;
      int   k;
      logic [31:0] held;

      vecs.push_back('{"wr full",      1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0});
      vecs.push_back('{"rd full",      1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{"wr byte1",     1'b1, 32'h8000_0012, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0});
      vecs.push_back('{"rd merged",    1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_ABEF, 1'b0});
      vecs.push_back('{"wr nomask",    1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0});
      vecs.push_back('{"rd unaligned", 1'b0, 32'h8000_0013, 32'h0,         4'b0000, 32'hDEAD_ABEF, 1'b0});
      vecs.push_back('{"wr word0",     1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0});
      vecs.push_back('{"rd below",     1'b0, 32'h7FFF_FFFC, 32'h0,         4'b0000, 32'h0, 1'b1});
      vecs.push_back('{"rd above",     1'b0, 32'h8000_1000, 32'h0,         4'b0000, 32'h0, 1'b1});
      vecs.push_back('{"wr above",     1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1});
      vecs.push_back('{"rd word0",     1'b0, 32'h8000_0000, 32'h0,         4'b0000, 32'hCAFE_F00D, 1'b0});
      vecs.push_back('{"wr last",      1'b1, 32'h8000_0FFC, 32'h0A0B_0C0D, 4'b1111, 32'h0, 1'b0});
      vecs.push_back('{"wr last 0101", 1'b1, 32'h8000_0FFC, 32'h1122_3344, 4'b0101, 32'h0, 1'b0});
      vecs.push_back('{"rd last",      1'b0, 32'h8000_0FFC, 32'h0,         4'b0000, 32'h0A22_0C44, 1'b0});

      // Reset held for 3 cycles, outputs idle throughout and after release.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset req_ready", 32'(req_ready), 32'd1);
         check("reset rsp_valid", 32'(rsp_valid), 32'd0);
         check("reset rsp_err", 32'(rsp_err), 32'd0);
         check("reset rsp_rdata", rsp_rdata, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      check("post-reset req_ready", 32'(req_ready), 32'd1);
      check("post-reset rsp_valid", 32'(rsp_valid), 32'd0);

      foreach (vecs[i])
         do_txn(vecs[i].name, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                vecs[i].exp_rdata, vecs[i].exp_err);

      // Backpressure: response held 5 cycles while ignored requests pulse.
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = 4'b0000;
      e.rdata = 32'hDEAD_ABEF; e.err = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      k = 1;
      while (!rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("bp latency", 32'(k), 32'(LAT));
      e = sb.pop_front();
      held = e.rdata;
      for (int i = 0; i < 5; i++) begin
         check("bp rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp rdata", rsp_rdata, held);
         check("bp req_ready", 32'(req_ready), 32'd0);
         req_valid = (i % 2 == 0); req_wen = 1'b1; req_addr = 32'h8000_0000;
         req_wdata = 32'h0; req_wmask = 4'b1111;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("bp rdata at hs", rsp_rdata, held);
      $display("txn backpressure read addr=80000010 rdata=%h", rsp_rdata);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("bp no extra rsp", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      do_txn("bp word0 intact", 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0);

      // Reset in WAIT aborts the write.
      do_txn("preload 20", 1'b1, 32'h8000_0020, 32'h1111_1111, 4'b1111, 32'h0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
      req_wdata = 32'h1234_5678; req_wmask = 4'b1111;
      @(negedge clk);
      req_valid = 1'b0;
      check("wait req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("abort req_ready", 32'(req_ready), 32'd1);
      check("abort rsp_valid", 32'(rsp_valid), 32'd0);
      $display("txn aborted write addr=80000020 wdata=12345678");
      @(negedge clk);
      rst = 1'b1;
      do_txn("rd after abort", 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 32'h1111_1111, 1'b0);

      // Reset in RESP drops the response but keeps the committed write.
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0024;
      req_wdata = 32'hA5A5_A5A5; req_wmask = 4'b1111;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("resp before reset", 32'(rsp_valid), 32'd1);
      rst = 1'b0;
      #1;
      check("resp dropped", 32'(rsp_valid), 32'd0);
      $display("txn dropped response write addr=80000024 wdata=a5a5a5a5");
      @(negedge clk);
      rst = 1'b1;
      do_txn("rd after drop", 1'b0, 32'h8000_0024, 32'h0, 4'b0000, 32'hA5A5_A5A5, 1'b0);

      check("scoreboard empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
